// File: rtl/ring_ctrl_4t.sv
// ring_ctrl_4t: LOTR ring stop between one gpc_4t tile and the ring
// Ports:
//   QClk, RstQnnnH             clock, synchronous active-high reset
//   CoreID                     this tile's ID (Address[31:24], Requestor[9:2])
//   RingIn*Q500H / RingOut*Q502H  ring slot in / out
//   C2F_Req*Q500H              core requests to inject onto the ring
//   C2F_Rsp*Q502H, C2F_RspStall   read responses to the core, core backpressure
//   F2C_Req*Q502H              remote accesses into this tile's memory
//   F2C_Rsp*Q500H              tile read data to return onto the ring
// Optional: define LOTR_RC_STATS_EN to add StatFwdCnt/StatConsumeCnt/StatInjectCnt.
package ring_ctrl_4t_pkg;
    typedef enum logic [1:0] {NOP = 2'd0, RD = 2'd1, WR = 2'd2, RD_RSP = 2'd3} t_opcode;
endpackage

module ring_ctrl_4t
    import ring_ctrl_4t_pkg::*;
#(
    parameter int C2F_FIFO_DEPTH = 4,
    parameter int F2C_FIFO_DEPTH = 4
) (
    input  logic        QClk,
    input  logic        RstQnnnH,
    input  logic [7:0]  CoreID,
    input  logic        RingInValidQ500H,
    input  t_opcode     RingInOpcodeQ500H,
    input  logic [31:0] RingInAddressQ500H,
    input  logic [31:0] RingInDataQ500H,
    input  logic [9:0]  RingInRequestorQ500H,
    output logic        RingOutValidQ502H,
    output t_opcode     RingOutOpcodeQ502H,
    output logic [31:0] RingOutAddressQ502H,
    output logic [31:0] RingOutDataQ502H,
    output logic [9:0]  RingOutRequestorQ502H,
    input  logic        C2F_ReqValidQ500H,
    input  t_opcode     C2F_ReqOpcodeQ500H,
    input  logic [1:0]  C2F_ReqThreadIDQ500H,
    input  logic [31:0] C2F_ReqAddressQ500H,
    input  logic [31:0] C2F_ReqDataQ500H,
    output logic        C2F_RspValidQ502H,
    output t_opcode     C2F_RspOpcodeQ502H,
    output logic [1:0]  C2F_RspThreadIDQ502H,
    output logic [31:0] C2F_RspDataQ502H,
    output logic        C2F_RspStall,
    output logic        F2C_ReqValidQ502H,
    output t_opcode     F2C_ReqOpcodeQ502H,
    output logic [31:0] F2C_ReqAddressQ502H,
    output logic [31:0] F2C_ReqDataQ502H,
    input  logic        F2C_RspValidQ500H,
    input  t_opcode     F2C_RspOpcodeQ500H,
    input  logic [31:0] F2C_RspAddressQ500H,
`ifdef LOTR_RC_STATS_EN
    output logic [31:0] StatFwdCnt,
    output logic [31:0] StatConsumeCnt,
    output logic [31:0] StatInjectCnt,
`endif
    input  logic [31:0] F2C_RspDataQ500H
);
    localparam int CAW = $clog2(C2F_FIFO_DEPTH);
    localparam int FAW = $clog2(F2C_FIFO_DEPTH);
    localparam logic [CAW:0] C2F_FULL = (CAW+1)'(C2F_FIFO_DEPTH);
    localparam logic [CAW:0] C2F_STALL_AT = (CAW+1)'(C2F_FIFO_DEPTH - 2);
    localparam logic [FAW:0] F2C_FULL = (FAW+1)'(F2C_FIFO_DEPTH);

    typedef struct packed {
        t_opcode     opcode;
        logic [31:0] address;
        logic [31:0] data;
        logic [9:0]  requestor;
    } t_slot;

    logic           ringValidQ501, c2fValidQ501;
    t_slot          ringQ501, c2fQ501, ringSel;
    t_slot          c2fMem [C2F_FIFO_DEPTH];
    logic [CAW-1:0] c2fWrPtr, c2fRdPtr;
    logic [CAW:0]   c2fCount;
    logic [63:0]    rspMem [F2C_FIFO_DEPTH];
    logic [FAW-1:0] rspWrPtr, rspRdPtr;
    logic [FAW:0]   rspCount;
    logic [9:0]     tagMem [F2C_FIFO_DEPTH];
    logic [FAW-1:0] tagWrPtr, tagRdPtr;
    logic [FAW:0]   tagCount;
    logic           consumeReq, consumeRsp, forward, injectRsp, injectC2f, ringOutValid;
    logic           c2fPush, rspPush, tagPush;
    logic           unusedOk;

    // Response opcode is implied (always RD_RSP on the ring).
    assign unusedOk = ^F2C_RspOpcodeQ500H;

    always_comb begin
        // A local RD with no tag space left is not consumed; it keeps circling.
        consumeReq = ringValidQ501 && (ringQ501.opcode == RD || ringQ501.opcode == WR)
                     && ringQ501.address[31:24] == CoreID
                     && !(ringQ501.opcode == RD && tagCount == F2C_FULL);
        consumeRsp = ringValidQ501 && ringQ501.opcode == RD_RSP && ringQ501.requestor[9:2] == CoreID;
        forward = ringValidQ501 && !consumeReq && !consumeRsp;
        injectRsp = !forward && rspCount != '0 && tagCount != '0;
        injectC2f = !forward && !injectRsp && c2fCount != '0;
        ringOutValid = forward || injectRsp || injectC2f;
        c2fPush = c2fValidQ501 && (c2fCount != C2F_FULL || injectC2f);
        rspPush = F2C_RspValidQ500H && (rspCount != F2C_FULL || injectRsp);
        tagPush = consumeReq && ringQ501.opcode == RD;
        ringSel = forward ? ringQ501 :
                  injectRsp ? t_slot'{RD_RSP, rspMem[rspRdPtr][63:32], rspMem[rspRdPtr][31:0], tagMem[tagRdPtr]} :
                  injectC2f ? c2fMem[c2fRdPtr] : '0;
    end

    always_ff @(posedge QClk) begin
        if (c2fPush) c2fMem[c2fWrPtr] <= c2fQ501;
        if (rspPush) rspMem[rspWrPtr] <= {F2C_RspAddressQ500H, F2C_RspDataQ500H};
        if (tagPush) tagMem[tagWrPtr] <= ringQ501.requestor;
    end

    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            ringValidQ501 <= 1'b0;
            ringQ501 <= '0;
            c2fValidQ501 <= 1'b0;
            c2fQ501 <= '0;
            c2fWrPtr <= '0;
            c2fRdPtr <= '0;
            c2fCount <= '0;
            rspWrPtr <= '0;
            rspRdPtr <= '0;
            rspCount <= '0;
            tagWrPtr <= '0;
            tagRdPtr <= '0;
            tagCount <= '0;
            RingOutValidQ502H <= 1'b0;
            RingOutOpcodeQ502H <= NOP;
            RingOutAddressQ502H <= '0;
            RingOutDataQ502H <= '0;
            RingOutRequestorQ502H <= '0;
            C2F_RspValidQ502H <= 1'b0;
            C2F_RspOpcodeQ502H <= NOP;
            C2F_RspThreadIDQ502H <= '0;
            C2F_RspDataQ502H <= '0;
            C2F_RspStall <= 1'b0;
            F2C_ReqValidQ502H <= 1'b0;
            F2C_ReqOpcodeQ502H <= NOP;
            F2C_ReqAddressQ502H <= '0;
            F2C_ReqDataQ502H <= '0;
        end else begin
            ringValidQ501 <= RingInValidQ500H;
            ringQ501 <= t_slot'{RingInOpcodeQ500H, RingInAddressQ500H, RingInDataQ500H, RingInRequestorQ500H};
            c2fValidQ501 <= C2F_ReqValidQ500H;
            c2fQ501 <= t_slot'{C2F_ReqOpcodeQ500H, C2F_ReqAddressQ500H, C2F_ReqDataQ500H, {CoreID, C2F_ReqThreadIDQ500H}};
            c2fWrPtr <= c2fWrPtr + CAW'(c2fPush);
            c2fRdPtr <= c2fRdPtr + CAW'(injectC2f);
            c2fCount <= c2fCount + (CAW+1)'(c2fPush) - (CAW+1)'(injectC2f);
            rspWrPtr <= rspWrPtr + FAW'(rspPush);
            rspRdPtr <= rspRdPtr + FAW'(injectRsp);
            rspCount <= rspCount + (FAW+1)'(rspPush) - (FAW+1)'(injectRsp);
            tagWrPtr <= tagWrPtr + FAW'(tagPush);
            tagRdPtr <= tagRdPtr + FAW'(injectRsp);
            tagCount <= tagCount + (FAW+1)'(tagPush) - (FAW+1)'(injectRsp);
            RingOutValidQ502H <= ringOutValid;
            RingOutOpcodeQ502H <= ringSel.opcode;
            RingOutAddressQ502H <= ringSel.address;
            RingOutDataQ502H <= ringSel.data;
            RingOutRequestorQ502H <= ringSel.requestor;
            C2F_RspValidQ502H <= consumeRsp;
            C2F_RspOpcodeQ502H <= consumeRsp ? RD_RSP : NOP;
            C2F_RspThreadIDQ502H <= consumeRsp ? ringQ501.requestor[1:0] : 2'd0;
            C2F_RspDataQ502H <= consumeRsp ? ringQ501.data : 32'd0;
            // Threshold leaves room for the request already at Q500 plus one more.
            C2F_RspStall <= c2fCount >= C2F_STALL_AT;
            F2C_ReqValidQ502H <= consumeReq;
            F2C_ReqOpcodeQ502H <= consumeReq ? ringQ501.opcode : NOP;
            F2C_ReqAddressQ502H <= consumeReq ? ringQ501.address : 32'd0;
            F2C_ReqDataQ502H <= consumeReq ? ringQ501.data : 32'd0;
        end
    end

`ifdef LOTR_RC_STATS_EN
    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            StatFwdCnt <= '0;
            StatConsumeCnt <= '0;
            StatInjectCnt <= '0;
        end else begin
            if (forward && StatFwdCnt != '1) StatFwdCnt <= StatFwdCnt + 32'd1;
            if ((consumeReq || consumeRsp) && StatConsumeCnt != '1) StatConsumeCnt <= StatConsumeCnt + 32'd1;
            if ((injectRsp || injectC2f) && StatInjectCnt != '1) StatInjectCnt <= StatInjectCnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ring_ctrl_4t.sv
// tb_ring_ctrl_4t: directed and random checks of ring_ctrl_4t against a queue-based model
module tb_ring_ctrl_4t;
    import ring_ctrl_4t_pkg::*;
    localparam int DEPTH = 4;

    typedef struct packed {
        t_opcode     op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [9:0]  req;
    } slot_t;

    logic        QClk = 1'b0;
    logic        RstQnnnH;
    logic [7:0]  CoreID;
    logic        RingInValidQ500H;
    t_opcode     RingInOpcodeQ500H;
    logic [31:0] RingInAddressQ500H, RingInDataQ500H;
    logic [9:0]  RingInRequestorQ500H;
    logic        RingOutValidQ502H;
    t_opcode     RingOutOpcodeQ502H;
    logic [31:0] RingOutAddressQ502H, RingOutDataQ502H;
    logic [9:0]  RingOutRequestorQ502H;
    logic        C2F_ReqValidQ500H;
    t_opcode     C2F_ReqOpcodeQ500H;
    logic [1:0]  C2F_ReqThreadIDQ500H;
    logic [31:0] C2F_ReqAddressQ500H, C2F_ReqDataQ500H;
    logic        C2F_RspValidQ502H;
    t_opcode     C2F_RspOpcodeQ502H;
    logic [1:0]  C2F_RspThreadIDQ502H;
    logic [31:0] C2F_RspDataQ502H;
    logic        C2F_RspStall;
    logic        F2C_ReqValidQ502H;
    t_opcode     F2C_ReqOpcodeQ502H;
    logic [31:0] F2C_ReqAddressQ502H, F2C_ReqDataQ502H;
    logic        F2C_RspValidQ500H;
    t_opcode     F2C_RspOpcodeQ500H;
    logic [31:0] F2C_RspAddressQ500H, F2C_RspDataQ500H;

    always #5 QClk = ~QClk;

    ring_ctrl_4t #(.C2F_FIFO_DEPTH(DEPTH), .F2C_FIFO_DEPTH(DEPTH)) dut (
        .QClk(QClk), .RstQnnnH(RstQnnnH), .CoreID(CoreID),
        .RingInValidQ500H(RingInValidQ500H), .RingInOpcodeQ500H(RingInOpcodeQ500H),
        .RingInAddressQ500H(RingInAddressQ500H), .RingInDataQ500H(RingInDataQ500H),
        .RingInRequestorQ500H(RingInRequestorQ500H),
        .RingOutValidQ502H(RingOutValidQ502H), .RingOutOpcodeQ502H(RingOutOpcodeQ502H),
        .RingOutAddressQ502H(RingOutAddressQ502H), .RingOutDataQ502H(RingOutDataQ502H),
        .RingOutRequestorQ502H(RingOutRequestorQ502H),
        .C2F_ReqValidQ500H(C2F_ReqValidQ500H), .C2F_ReqOpcodeQ500H(C2F_ReqOpcodeQ500H),
        .C2F_ReqThreadIDQ500H(C2F_ReqThreadIDQ500H), .C2F_ReqAddressQ500H(C2F_ReqAddressQ500H),
        .C2F_ReqDataQ500H(C2F_ReqDataQ500H),
        .C2F_RspValidQ502H(C2F_RspValidQ502H), .C2F_RspOpcodeQ502H(C2F_RspOpcodeQ502H),
        .C2F_RspThreadIDQ502H(C2F_RspThreadIDQ502H), .C2F_RspDataQ502H(C2F_RspDataQ502H),
        .C2F_RspStall(C2F_RspStall),
        .F2C_ReqValidQ502H(F2C_ReqValidQ502H), .F2C_ReqOpcodeQ502H(F2C_ReqOpcodeQ502H),
        .F2C_ReqAddressQ502H(F2C_ReqAddressQ502H), .F2C_ReqDataQ502H(F2C_ReqDataQ502H),
        .F2C_RspValidQ500H(F2C_RspValidQ500H), .F2C_RspOpcodeQ500H(F2C_RspOpcodeQ500H),
        .F2C_RspAddressQ500H(F2C_RspAddressQ500H), .F2C_RspDataQ500H(F2C_RspDataQ500H)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(string tag, logic [79:0] obs, logic [79:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference model: ring slot and core request waiting at Q501, plus three queues.
    slot_t       mRing, mCore;
    logic        mRingV = 1'b0, mCoreV = 1'b0;
    slot_t       cq[$];
    slot_t       rq[$];
    logic [9:0]  tq[$];
    logic [79:0] expRing = '0, expF2c = '0, expC2f = '0;
    logic        expStall = 1'b0;

    function automatic logic [79:0] ringVec(slot_t s);
        return {3'b0, 1'b1, s};
    endfunction

    task automatic modelStep();
        logic cReq, cRsp, fwd;
        slot_t h;
        expRing = '0;
        expF2c = '0;
        expC2f = '0;
        if (RstQnnnH) begin
            cq.delete();
            rq.delete();
            tq.delete();
            mRingV = 1'b0;
            mCoreV = 1'b0;
            expStall = 1'b0;
            return;
        end
        expStall = cq.size() >= DEPTH - 2;
        cReq = mRingV && mRing.op inside {RD, WR} && mRing.addr[31:24] == CoreID
               && !(mRing.op == RD && tq.size() == DEPTH);
        cRsp = mRingV && mRing.op == RD_RSP && mRing.req[9:2] == CoreID;
        fwd = mRingV && !cReq && !cRsp;
        if (fwd) expRing = ringVec(mRing);
        else if (rq.size() != 0 && tq.size() != 0) begin
            h = rq.pop_front();
            h.op = RD_RSP;
            h.req = tq.pop_front();
            expRing = ringVec(h);
        end else if (cq.size() != 0) expRing = ringVec(cq.pop_front());
        if (cReq) expF2c = {13'b0, 1'b1, mRing.op, mRing.addr, mRing.data};
        if (cReq && mRing.op == RD) tq.push_back(mRing.req);
        if (cRsp) expC2f = {43'b0, 1'b1, RD_RSP, mRing.req[1:0], mRing.data};
        if (mCoreV && cq.size() < DEPTH) cq.push_back(mCore);
        if (F2C_RspValidQ500H && rq.size() < DEPTH)
            rq.push_back(slot_t'{NOP, F2C_RspAddressQ500H, F2C_RspDataQ500H, 10'd0});
        mRingV = RingInValidQ500H;
        mRing = slot_t'{RingInOpcodeQ500H, RingInAddressQ500H, RingInDataQ500H, RingInRequestorQ500H};
        mCoreV = C2F_ReqValidQ500H;
        mCore = slot_t'{C2F_ReqOpcodeQ500H, C2F_ReqAddressQ500H, C2F_ReqDataQ500H, {CoreID, C2F_ReqThreadIDQ500H}};
    endtask

    task automatic tick();
        @(posedge QClk);
        modelStep();
        #1;
        check("ring", RingOutValidQ502H ? {3'b0, 1'b1, RingOutOpcodeQ502H, RingOutAddressQ502H,
              RingOutDataQ502H, RingOutRequestorQ502H} : 80'd0, expRing);
        check("f2c", F2C_ReqValidQ502H ? {13'b0, 1'b1, F2C_ReqOpcodeQ502H, F2C_ReqAddressQ502H,
              F2C_ReqDataQ502H} : 80'd0, expF2c);
        check("c2f", C2F_RspValidQ502H ? {43'b0, 1'b1, C2F_RspOpcodeQ502H, C2F_RspThreadIDQ502H,
              C2F_RspDataQ502H} : 80'd0, expC2f);
        check("stall", {79'b0, C2F_RspStall}, {79'b0, expStall});
    endtask

    task automatic checkAllZero(string tag);
        check({tag, "_ring"}, {3'b0, RingOutValidQ502H, RingOutOpcodeQ502H, RingOutAddressQ502H,
              RingOutDataQ502H, RingOutRequestorQ502H}, 80'd0);
        check({tag, "_f2c"}, {13'b0, F2C_ReqValidQ502H, F2C_ReqOpcodeQ502H, F2C_ReqAddressQ502H,
              F2C_ReqDataQ502H}, 80'd0);
        check({tag, "_c2f"}, {43'b0, C2F_RspValidQ502H, C2F_RspOpcodeQ502H, C2F_RspThreadIDQ502H,
              C2F_RspDataQ502H}, 80'd0);
        check({tag, "_stall"}, {79'b0, C2F_RspStall}, 80'd0);
    endtask

    task automatic setRing(logic v, t_opcode op, logic [31:0] a, logic [31:0] d, logic [9:0] r);
        RingInValidQ500H = v;
        RingInOpcodeQ500H = op;
        RingInAddressQ500H = a;
        RingInDataQ500H = d;
        RingInRequestorQ500H = r;
    endtask

    task automatic setCore(logic v, t_opcode op, logic [1:0] t, logic [31:0] a, logic [31:0] d);
        C2F_ReqValidQ500H = v;
        C2F_ReqOpcodeQ500H = op;
        C2F_ReqThreadIDQ500H = t;
        C2F_ReqAddressQ500H = a;
        C2F_ReqDataQ500H = d;
    endtask

    task automatic setRsp(logic v, logic [31:0] a, logic [31:0] d);
        F2C_RspValidQ500H = v;
        F2C_RspOpcodeQ500H = v ? RD_RSP : NOP;
        F2C_RspAddressQ500H = a;
        F2C_RspDataQ500H = d;
    endtask

    task automatic idleAll();
        setRing(1'b0, NOP, 32'd0, 32'd0, 10'd0);
        setCore(1'b0, NOP, 2'd0, 32'd0, 32'd0);
        setRsp(1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] got[$];
        int pending;
        CoreID = 8'h03;
        idleAll();
        RstQnnnH = 1'b1;
        tick();
        tick();
        checkAllZero("rst");
        RstQnnnH = 1'b0;

        // Remote RD into this tile, then its response back onto the ring.
        setRing(1'b1, RD, 32'h0300_0010, 32'd0, 10'h021);
        tick();
        idleAll();
        tick();
        check("rd_f2c", {47'b0, F2C_ReqValidQ502H, F2C_ReqAddressQ502H}, {47'b0, 1'b1, 32'h0300_0010});
        setRsp(1'b1, 32'h0300_0010, 32'hDEAD_BEEF);
        tick();
        idleAll();
        tick();
        check("rd_rsp", {35'b0, RingOutValidQ502H, RingOutOpcodeQ502H, RingOutDataQ502H, RingOutRequestorQ502H},
              {35'b0, 1'b1, RD_RSP, 32'hDEAD_BEEF, 10'h021});

        // RD_RSP for core 3 thread 2 goes to the core and leaves the slot empty.
        setRing(1'b1, RD_RSP, 32'd0, 32'h1234_5678, 10'h00E);
        tick();
        idleAll();
        tick();
        check("rsp_c2f", {45'b0, C2F_RspValidQ502H, C2F_RspThreadIDQ502H, C2F_RspDataQ502H},
              {45'b0, 1'b1, 2'd2, 32'h1234_5678});
        check("rsp_ringIdle", {79'b0, RingOutValidQ502H}, 80'd0);

        // Foreign WR is forwarded; pending core request waits for the free slot.
        setRing(1'b1, WR, 32'h0500_0000, 32'h0000_AAAA, 10'h0C1);
        setCore(1'b1, WR, 2'd1, 32'h0700_0000, 32'h0000_5555);
        tick();
        setCore(1'b0, NOP, 2'd0, 32'd0, 32'd0);
        tick();
        check("fwd", {45'b0, RingOutValidQ502H, RingOutOpcodeQ502H, RingOutAddressQ502H},
              {45'b0, 1'b1, WR, 32'h0500_0000});
        tick();
        idleAll();
        tick();
        tick();
        check("inj", {13'b0, RingOutValidQ502H, RingOutOpcodeQ502H, RingOutAddressQ502H, RingOutDataQ502H},
              {13'b0, 1'b1, WR, 32'h0700_0000, 32'h0000_5555});

        // Four back-to-back core writes while the ring is saturated.
        setRing(1'b1, WR, 32'h0500_0100, 32'h0000_BBBB, 10'h0C2);
        for (int i = 0; i < 4; i++) begin
            setCore(1'b1, WR, 2'(i), 32'h0700_0000 + 32'(i), 32'hC0DE_0000 + 32'(i));
            tick();
        end
        setCore(1'b0, NOP, 2'd0, 32'd0, 32'd0);
        check("burst_stall", {79'b0, C2F_RspStall}, {79'b0, 1'b1});
        tick();
        tick();
        setRing(1'b0, NOP, 32'd0, 32'd0, 10'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (RingOutValidQ502H && RingOutOpcodeQ502H == WR && RingOutAddressQ502H[31:24] == 8'h07)
                got.push_back(RingOutDataQ502H);
        end
        check("burst_count", 80'(got.size()), 80'd4);
        for (int i = 0; i < got.size() && i < 4; i++)
            check("burst_order", {48'b0, got[i]}, {48'b0, 32'hC0DE_0000 + 32'(i)});

        // Fill the tag FIFO; a fifth local RD must circulate.
        for (int i = 0; i < 4; i++) begin
            setRing(1'b1, RD, 32'h0300_0100 + 32'(4 * i), 32'd0, {8'h05, 2'(i)});
            tick();
        end
        setRing(1'b1, RD, 32'h0300_0200, 32'd0, 10'h015);
        tick();
        idleAll();
        tick();
        check("tagfull_noF2c", {79'b0, F2C_ReqValidQ502H}, 80'd0);
        check("tagfull_fwd", {45'b0, RingOutValidQ502H, RingOutOpcodeQ502H, RingOutAddressQ502H},
              {45'b0, 1'b1, RD, 32'h0300_0200});
        for (int i = 0; i < 4; i++) begin
            setRsp(1'b1, 32'h0300_0100 + 32'(4 * i), 32'hF00D_0000 + 32'(i));
            tick();
        end
        idleAll();
        for (int i = 0; i < 6; i++) tick();
        setRing(1'b1, RD, 32'h0300_0200, 32'd0, 10'h015);
        tick();
        idleAll();
        tick();
        check("tagfree_consume", {47'b0, F2C_ReqValidQ502H, F2C_ReqAddressQ502H}, {47'b0, 1'b1, 32'h0300_0200});
        tick();

        // Reset with queued traffic everywhere.
        setRing(1'b1, RD, 32'h0300_0300, 32'd0, 10'h031);
        tick();
        setRing(1'b1, RD, 32'h0300_0304, 32'd0, 10'h032);
        tick();
        setRing(1'b1, WR, 32'h0600_0000, 32'h0000_CCCC, 10'h0C3);
        for (int i = 0; i < 3; i++) begin
            setCore(1'b1, WR, 2'(i), 32'h0700_0100, 32'hBEEF_0000 + 32'(i));
            setRsp(i < 2, 32'h0300_0300, 32'hAB00_0000 + 32'(i));
            tick();
        end
        setRsp(1'b0, 32'd0, 32'd0);
        RstQnnnH = 1'b1;
        tick();
        checkAllZero("midrst");
        RstQnnnH = 1'b0;
        idleAll();
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_stale", {79'b0, RingOutValidQ502H}, 80'd0);
        end

        // Random traffic against the model.
        pending = 0;
        for (int n = 0; n < 3000; n++) begin
            RstQnnnH = $urandom_range(0, 499) == 0;
            setRing($urandom_range(0, 9) < 7, t_opcode'($urandom_range(1, 3)),
                    {($urandom_range(0, 1) != 0) ? CoreID : 8'($urandom), 24'($urandom)}, $urandom,
                    {($urandom_range(0, 1) != 0) ? CoreID : 8'($urandom), 2'($urandom)});
            setCore(!expStall && $urandom_range(0, 9) < 4, t_opcode'($urandom_range(1, 2)), 2'($urandom),
                    $urandom, $urandom);
            if (pending > 0 && $urandom_range(0, 1) != 0) begin
                setRsp(1'b1, $urandom, $urandom);
                pending--;
            end else setRsp(1'b0, 32'd0, 32'd0);
            tick();
            if (RstQnnnH) pending = 0;
            else if (expF2c[66] && expF2c[65:64] == RD) pending++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ring_ctrl_4t.md
Name: ring_ctrl_4t

Overview:
- Ring stop that sits directly between one gpc_4t tile and the LOTR ring.
- Consumes the tile's C2F requests and F2C responses, and produces the tile's F2C requests and C2F responses.
- Forwards all ring traffic not addressed to this tile.
- Buffers core-injected traffic in FIFOs and backpressures the core through C2F_RspStall.

Parameters:
- C2F_FIFO_DEPTH, 4, entries in the C2F request injection FIFO (power of 2, >=4).
- F2C_FIFO_DEPTH, 4, entries in the F2C response FIFO and in the read-tag FIFO (power of 2, >=4).

Ports:
- QClk  in  1  clock
- RstQnnnH  in  1  synchronous active-high reset
- CoreID  in  8  tile ID; matches Address[31:24] and Requestor[9:2]
- RingInValidQ500H  in  1  ring slot valid
- RingInOpcodeQ500H  in  t_opcode  RD / WR / RD_RSP
- RingInAddressQ500H  in  32  target address
- RingInDataQ500H  in  32  payload
- RingInRequestorQ500H  in  10  {CoreID, ThreadID} of the originator
- RingOutValidQ502H  out  1  ring slot out
- RingOutOpcodeQ502H  out  t_opcode
- RingOutAddressQ502H  out  32
- RingOutDataQ502H  out  32
- RingOutRequestorQ502H  out  10
- C2F_ReqValidQ500H  in  1  core request
- C2F_ReqOpcodeQ500H  in  t_opcode
- C2F_ReqThreadIDQ500H  in  2
- C2F_ReqAddressQ500H  in  32
- C2F_ReqDataQ500H  in  32
- C2F_RspValidQ502H  out  1  read response to core
- C2F_RspOpcodeQ502H  out  t_opcode
- C2F_RspThreadIDQ502H  out  2
- C2F_RspDataQ502H  out  32
- C2F_RspStall  out  1  core must not issue new C2F requests
- F2C_ReqValidQ502H  out  1  remote access into this tile's memory
- F2C_ReqOpcodeQ502H  out  t_opcode
- F2C_ReqAddressQ502H  out  32
- F2C_ReqDataQ502H  out  32
- F2C_RspValidQ500H  in  1  tile read-data response
- F2C_RspOpcodeQ500H  in  t_opcode
- F2C_RspAddressQ500H  in  32
- F2C_RspDataQ500H  in  32

Behaviour:
- Reset (synchronous, RstQnnnH=1 at a QClk edge):
  - all outputs 0;
  - FIFOs emptied and pointers/counts 0;
  - in-flight ring slot and queued traffic dropped.
  - Reset mid-operation follows the same rule; no partial transfer survives.
- Q500->Q501: ring input and the C2F request are flopped unconditionally. A valid C2F request is pushed into the C2F FIFO at Q501 with Requestor={CoreID, ThreadID}.
- Q501 slot decision for a valid ring slot, in priority order:
  - a) RD or WR with Address[31:24]==CoreID:
    - consume the slot and drive F2C_Req* at Q502 (fixed 2-cycle latency);
    - RD additionally pushes Requestor into the tag FIFO;
    - if the opcode is RD and the tag FIFO is full, do not consume: forward unchanged (the request recirculates).
  - b) RD_RSP with Requestor[9:2]==CoreID: consume and drive C2F_Rsp* at Q502 with ThreadID=Requestor[1:0].
  - c) otherwise forward unchanged to RingOut* at Q502.
- Free slot (ring slot invalid or consumed) is filled in this priority:
  - 1) head of the F2C response FIFO, emitted as RD_RSP with the address and data from that entry and Requestor popped from the tag FIFO;
  - 2) head of the C2F FIFO.
  - Otherwise RingOutValid=0.
- F2C response FIFO:
  - pushed on F2C_RspValidQ500H;
  - responses return in order, so tag FIFO pop pairs 1:1 with response FIFO pop;
  - push while full is a protocol error; the design guarantees it never happens because tag depth equals response depth.
- C2F_RspStall = C2F FIFO count >= C2F_FIFO_DEPTH-2, covering the request already in flight at Q500 plus one more. It is registered and deasserts the cycle after count drops below the threshold.
- Simultaneous push and pop on any FIFO in one cycle: count unchanged, both honoured, including at full and at empty.
- Pointers wrap modulo depth.
- Forwarded traffic always beats injection. No starvation guard exists.

Optional Feature:
- Macro: LOTR_RC_STATS_EN.
- With the macro defined:
  - adds outputs StatFwdCnt, StatConsumeCnt, StatInjectCnt, each 32 bits;
  - each counter increments by 1 per forwarded, consumed, or injected slot;
  - counters saturate at 32'hFFFF_FFFF and reset to 0.
- Without the macro: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- CoreID=8'h03; ring RD addr 32'h0300_0010, requestor 10'h021 -> F2C_ReqValidQ502H=1, addr 32'h0300_0010 two cycles later. Then drive F2C_Rsp data 32'hDEAD_BEEF -> RingOut RD_RSP, data 32'hDEAD_BEEF, requestor 10'h021.
- Ring RD_RSP, requestor 10'h00E (core 3, thread 2), data 32'h1234_5678 -> C2F_RspValidQ502H=1, ThreadID=2, data 32'h1234_5678; RingOutValid=0 that cycle.
- Ring WR addr 32'h0500_0000 (other core) -> forwarded unchanged at Q502; a pending C2F request stays queued until the next free slot.
- Core issues 4 back-to-back C2F WR requests while the ring is fully occupied by foreign traffic -> C2F_RspStall=1 after the 2nd push; no request lost; the 4 requests appear in order once the ring frees.
- Fill the tag FIFO (4 remote RDs, responses withheld); a 5th RD to this core -> forwarded around the ring, no F2C_Req; after responses drain, a re-arriving RD is consumed.
- Assert RstQnnnH mid-stream with FIFOs non-empty -> next cycle all outputs 0 and C2F_RspStall=0; no stale response emitted after reset release.
